// File: rtl/pipeline_1_pkg.sv
// Shared definitions for the pipeline_1 divider: default width and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipeline_1_pkg;

    // Default operand / result width in bits.
    localparam int DEF_N = 10;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_1_div_if.sv
// Operand/result handshake bundle for the pipeline_1 divider.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//   slave  : the divider (takes operands, produces results)
//   master : the upstream/downstream driver (e.g. a testbench)
interface pipeline_1_div_if
    import pipeline_1_pkg::*;
#(
    parameter int N = DEF_N
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] f_in;
    logic [N-1:0] d_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] x3_out;
    logic [N-1:0] rem_out;
    logic         div_zero;

    modport slave (
        input  in_valid, f_in, d_in, out_ready,
        output in_ready, out_valid, x3_out, rem_out, div_zero
    );

    modport master (
        output in_valid, f_in, d_in, out_ready,
        input  in_ready, out_valid, x3_out, rem_out, div_zero
    );
endinterface

// File: rtl/pipeline_1_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
//   i_rem : current partial remainder (always < i_d)
//   i_bit : next dividend bit, MSB first
//   i_d   : divisor (non-zero)
//   o_rem : updated partial remainder
//   o_q   : quotient bit produced by this step
module pipeline_1_div_step
    import pipeline_1_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_rem,
    output logic         o_q
);

    logic [N:0] w_shift;
    logic [N:0] w_trial;

    // The shifted remainder needs N+1 bits: it can reach 2*(D-1)+1.
    assign w_shift = {i_rem, i_bit};
    assign w_trial = w_shift - {1'b0, i_d};

    // Since w_shift < 2*D and D < 2^N, the trial difference lies in (-D, D),
    // so its top bit is exactly the borrow: clear means w_shift >= D.
    assign o_q   = ~w_trial[N];
    assign o_rem = o_q ? w_trial[N-1:0] : w_shift[N-1:0];

endmodule

// File: rtl/pipeline_1_div.sv
// Unsigned restoring divider recovering x3 = floor(F/D) and F mod D from stage 3.
// Latency: N cycles from accept to out_valid (1 cycle when D == 0); one result per N+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no data change meanwhile.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : operand (in_valid/in_ready/f_in/d_in) and result
//                (out_valid/out_ready/x3_out/rem_out/div_zero) handshakes
module pipeline_1_div
    import pipeline_1_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic              clk,
    input  logic              rst_n,
    pipeline_1_div_if.slave   bus
);

    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_f;       // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [N-1:0]  r_d;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_x3;
    logic [N-1:0]  r_rem_o;
    logic          r_dz;

    logic          w_accept;
    logic          w_d_zero;
    logic          w_last;
    logic [N-1:0]  w_step_rem;
    logic          w_step_q;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_d_zero = (bus.d_in == '0);
    assign w_last   = (r_cnt == '0);

    pipeline_1_div_step #(
        .N (N)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_f[N-1]),
        .i_d   (r_d),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    // A zero divisor has nothing to iterate: report immediately.
                    w_state_nxt = w_d_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_f     <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_x3    <= '0;
            r_rem_o <= '0;
            r_dz    <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= CNT_LAST;
            r_f   <= bus.f_in;
            r_d   <= bus.d_in;
            r_rem <= '0;
            if (w_d_zero) begin
                r_x3    <= '1;
                r_rem_o <= bus.f_in;
                r_dz    <= 1'b1;
            end
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 1'b1;
            r_f   <= {r_f[N-2:0], w_step_q};
            r_rem <= w_step_rem;
            // Result registers change only on entry to DONE, so they hold
            // the previous result through IDLE and BUSY.
            if (w_last) begin
                r_x3    <= {r_f[N-2:0], w_step_q};
                r_rem_o <= w_step_rem;
                r_dz    <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.x3_out    = r_x3;
    assign bus.rem_out   = r_rem_o;
    assign bus.div_zero  = r_dz;

endmodule

// File: tb/tb_pipeline_1_div.sv
// Self-checking bench for pipeline_1_div (N = 10): directed boundary cases plus random scoreboard.
// Latency: n/a.
// Backpressure: drives out_ready both held and randomised.
module tb_pipeline_1_div;

    localparam int N = 10;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst_n;

    pipeline_1_div_if #(.N(N)) bus ();

    pipeline_1_div #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: a result is consumed at the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_x3",  32'(bus.x3_out),   32'(e.q));
                check("sb_rem", 32'(bus.rem_out),  32'(e.r));
                check("sb_dz",  32'(bus.div_zero), 32'(e.dz));
            end
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic do_accept(input logic [N-1:0] f, input logic [N-1:0] d,
                             input bit push, output time t_acc);
        int   w;
        exp_t e;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.f_in     = f;
        bus.d_in     = d;
        @(posedge clk);
        t_acc = $time;
        if (push) begin
            if (d == '0) begin
                e.q = '1; e.r = f; e.dz = 1'b1;
            end else begin
                e.q = f / d; e.r = f % d; e.dz = 1'b0;
            end
            exp_q.push_back(e);
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.out_valid && n < 50);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        time t0, t1, t2, tx;
        int  n;
        bit  rnd_done;

        bus.in_valid  = 1'b0;
        bus.f_in      = '0;
        bus.d_in      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_x3",        32'(bus.x3_out),    32'd0);
        check("rst_rem",       32'(bus.rem_out),   32'd0);
        check("rst_dz",        32'(bus.div_zero),  32'd0);
        rst_n = 1'b1;

        // Basic divide 1000 / 8
        do_accept(10'd1000, 10'd8, 1'b1, t0);
        check("basic_busy_in_ready", 32'(bus.in_ready), 32'd0);
        wait_valid(n);
        check("basic_latency", 32'(n), 32'd10);
        @(posedge clk); #1;
        check("basic_back_idle", 32'(bus.in_ready), 32'd1);
        check("basic_x3_retained", 32'(bus.x3_out), 32'd125);

        // Back-to-back boundaries
        do_accept(10'd1023, 10'd1,    1'b1, t0);
        do_accept(10'd7,    10'd10,   1'b1, t1);
        check("b2b_gap1", 32'((t1 - t0) / 10), 32'd12);
        do_accept(10'd1023, 10'd1023, 1'b1, t2);
        check("b2b_gap2", 32'((t2 - t1) / 10), 32'd12);
        drain();

        // F = 0
        do_accept(10'd0, 10'd37, 1'b1, tx);
        drain();

        // Divide by zero
        do_accept(10'd300, 10'd0, 1'b1, tx);
        check("dz_latency_valid", 32'(bus.out_valid), 32'd1);
        drain();

        // Backpressure hold
        bus.out_ready = 1'b0;
        do_accept(10'd999, 10'd3, 1'b1, tx);
        wait_valid(n);
        check("bp_latency", 32'(n), 32'd10);
        bus.in_valid = 1'b1;
        bus.f_in     = 10'd5;
        bus.d_in     = 10'd5;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_valid",    32'(bus.out_valid), 32'd1);
            check("bp_x3",       32'(bus.x3_out),    32'd333);
            check("bp_rem",      32'(bus.rem_out),   32'd0);
            check("bp_in_ready", 32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_in_ready",  32'(bus.in_ready),  32'd1);
        check("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-BUSY: the pending result is discarded
        do_accept(10'd500, 10'd7, 1'b0, tx);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_x3",        32'(bus.x3_out),    32'd0);
        check("mid_rst_rem",       32'(bus.rem_out),   32'd0);
        check("mid_rst_dz",        32'(bus.div_zero),  32'd0);
        repeat (2) @(posedge clk);
        #2;
        check("mid_rst_hold_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1;
        bus.f_in     = 10'd500;
        bus.d_in     = 10'd7;
        rst_n        = 1'b1;
        do_accept(10'd500, 10'd7, 1'b1, tx);
        wait_valid(n);
        check("post_rst_latency", 32'(n), 32'd10);
        drain();

        // Random with random out_ready
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [N-1:0] f, d;
                    int           sel;
                    sel = $urandom_range(0, 9);
                    f   = N'($urandom_range(0, 1023));
                    if (sel == 0)      d = '0;
                    else if (sel < 3)  d = N'($urandom_range(1, 4));
                    else               d = N'($urandom_range(1, 1023));
                    do_accept(f, d, 1'b1, tx);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
